// File: rtl/alu_divrem_pkg.sv
// Shared ALU definitions for the iterative divider: opcodes, FSM states and
// the two's-complement helper used for operand magnitudes and result signs.
package alu_divrem_pkg;

    localparam logic [4:0] OP_DIV  = 5'd20;
    localparam logic [4:0] OP_DIVU = 5'd21;
    localparam logic [4:0] OP_REM  = 5'd22;
    localparam logic [4:0] OP_REMU = 5'd23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic [31:0] twoscomp(input logic [31:0] val);
        return ~val + 32'd1;
    endfunction

    // Opcode bit 0 clear means signed, bit 1 set means remainder.
    function automatic logic is_div_op(input logic [4:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/alu_divrem_div_step.sv
// One restoring shift-subtract iteration: shifts {rem, quo} left by one and
// keeps the trial difference when it does not go negative.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic [W-1:0] quo_out
);

    logic [W:0] shifted;
    logic       ge;

    always_comb begin
        shifted = {rem_in, quo_in[W-1]};
        // A set carry-out bit means the shifted remainder already exceeds any divisor.
        ge      = shifted[W] | (shifted[W-1:0] >= divisor);
        rem_out = shifted[W-1:0] - (ge ? divisor : {W{1'b0}});
        quo_out = {quo_in[W-2:0], ge};
    end

endmodule

// File: rtl/alu_divrem.sv
// Iterative 32-bit DIV/DIVU/REM/REMU unit: one quotient bit per cycle on
// operand magnitudes, sign fix-up and result registration in DONE.
//
// state | meaning
// IDLE  | waiting for a divide opcode with dat_ready
// RUN   | 32 restoring steps, cnt_q counts 0..31
// DONE  | apply signs, register Div_out and flags, pulse Div_valid
module alu_divrem
    import alu_divrem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            soc_clk,
    input  logic            reset,
    input  logic            dat_ready,
    input  logic [XLEN-1:0] ALU_dat1,
    input  logic [XLEN-1:0] ALU_dat2,
    input  logic [4:0]      decryptedOP,
    output logic [XLEN-1:0] Div_out,
    output logic            Div_valid,
    output logic            Div_busy,
    output logic            Div_zero,
    output logic            Div_divbyzero,
    output logic            Div_overflow
);

    div_state_t      state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            is_rem_q, is_rem_d;
    logic            qsign_q, qsign_d;
    logic            rsign_q, rsign_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    logic [XLEN-1:0] out_q, out_d;
    logic            valid_q, valid_d;
    logic            zero_q, zero_d;
    logic            divbyzero_q, divbyzero_d;
    logic            overflow_q, overflow_d;

    logic            accept;
    logic            op_signed;
    logic            sign1;
    logic            sign2;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] result;

    assign accept    = dat_ready && is_div_op(decryptedOP);
    assign op_signed = ~decryptedOP[0];
    assign sign1     = op_signed & ALU_dat1[XLEN-1];
    assign sign2     = op_signed & ALU_dat2[XLEN-1];

    div_step #(.W(XLEN)) u_div_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // On divide by zero RUN is skipped, so quo_q still holds the dividend
    // magnitude and re-applying its sign recovers the original ALU_dat1.
    always_comb begin
        quo_fix = qsign_q ? twoscomp(quo_q) : quo_q;
        rem_fix = rsign_q ? twoscomp(rem_q) : rem_q;
        if (dbz_q) begin
            quo_fix = {XLEN{1'b1}};
            rem_fix = rsign_q ? twoscomp(quo_q) : quo_q;
        end
        result = is_rem_q ? rem_fix : quo_fix;
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        is_rem_d    = is_rem_q;
        qsign_d     = qsign_q;
        rsign_d     = rsign_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        out_d       = out_q;
        valid_d     = 1'b0;
        zero_d      = zero_q;
        divbyzero_d = divbyzero_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_rem_d = decryptedOP[1];
                    qsign_d  = sign1 ^ sign2;
                    rsign_d  = sign1;
                    quo_d    = sign1 ? twoscomp(ALU_dat1) : ALU_dat1;
                    dvs_d    = sign2 ? twoscomp(ALU_dat2) : ALU_dat2;
                    rem_d    = '0;
                    cnt_d    = '0;
                    dbz_d    = (ALU_dat2 == '0);
                    ovf_d    = op_signed && (ALU_dat1 == {1'b1, {(XLEN-1){1'b0}}})
                                         && (ALU_dat2 == {XLEN{1'b1}});
                    state_d  = (ALU_dat2 == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_d       = result;
                zero_d      = (result == '0);
                divbyzero_d = dbz_q;
                overflow_d  = ovf_q;
                valid_d     = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge soc_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            is_rem_q    <= 1'b0;
            qsign_q     <= 1'b0;
            rsign_q     <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            zero_q      <= 1'b0;
            divbyzero_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            is_rem_q    <= is_rem_d;
            qsign_q     <= qsign_d;
            rsign_q     <= rsign_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            zero_q      <= zero_d;
            divbyzero_q <= divbyzero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign Div_out       = out_q;
    assign Div_valid     = valid_q;
    assign Div_busy      = (state_q != IDLE);
    assign Div_zero      = zero_q;
    assign Div_divbyzero = divbyzero_q;
    assign Div_overflow  = overflow_q;

endmodule

// File: tb/tb_alu_divrem.sv
// Self-checking bench for alu_divrem: vector table, reference-model random
// ops, and hand sequences for reset, held inputs and back-to-back accepts.
module tb_alu_divrem;

    logic        soc_clk;
    logic        reset;
    logic        dat_ready;
    logic [31:0] ALU_dat1;
    logic [31:0] ALU_dat2;
    logic [4:0]  decryptedOP;
    logic [31:0] Div_out;
    logic        Div_valid;
    logic        Div_busy;
    logic        Div_zero;
    logic        Div_divbyzero;
    logic        Div_overflow;

    alu_divrem #(.XLEN(32)) dut (
        .soc_clk       (soc_clk),
        .reset         (reset),
        .dat_ready     (dat_ready),
        .ALU_dat1      (ALU_dat1),
        .ALU_dat2      (ALU_dat2),
        .decryptedOP   (decryptedOP),
        .Div_out       (Div_out),
        .Div_valid     (Div_valid),
        .Div_busy      (Div_busy),
        .Div_zero      (Div_zero),
        .Div_divbyzero (Div_divbyzero),
        .Div_overflow  (Div_overflow)
    );

    typedef struct {
        logic [31:0] out;
        logic        zero;
        logic        dbz;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        zero;
        logic        dbz;
        logic        ovf;
        int          lat;
    } vec_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_out = 32'h0;

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] q;
        logic [31:0] r;
        logic        sgn;
        sgn   = (op == 5'd20) || (op == 5'd22);
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (b == 32'h0) begin
            q     = 32'hFFFF_FFFF;
            r     = a;
            e.dbz = 1'b1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q     = 32'h8000_0000;
            r     = 32'h0;
            e.ovf = 1'b1;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        e.out  = (op == 5'd22 || op == 5'd23) ? r : q;
        e.zero = (e.out == 32'h0);
        return e;
    endfunction

    // Scoreboard monitor: every valid pulse must match the oldest pending op.
    always @(negedge soc_clk) begin
        exp_t e;
        if (!reset && Div_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=1 expected=0 out=%h", Div_out);
            end else begin
                e = sb.pop_front();
                chk("div_out", Div_out, e.out);
                chk("div_zero", {31'b0, Div_zero}, {31'b0, e.zero});
                chk("div_divbyzero", {31'b0, Div_divbyzero}, {31'b0, e.dbz});
                chk("div_overflow", {31'b0, Div_overflow}, {31'b0, e.ovf});
            end
        end
    end

    // Called at a negedge just after the accept edge; returns at the valid negedge.
    task automatic wait_valid(output int n, output int busy_n);
        n      = 0;
        busy_n = 0;
        while (!Div_valid && n < 100) begin
            if (Div_busy) busy_n++;
            @(negedge soc_clk);
            n++;
        end
    endtask

    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input int lat);
        int n;
        int bn;
        dat_ready   = 1'b1;
        decryptedOP = op;
        ALU_dat1    = a;
        ALU_dat2    = b;
        sb.push_back(e);
        last_out = e.out;
        @(posedge soc_clk);
        @(negedge soc_clk);
        dat_ready = 1'b0;
        wait_valid(n, bn);
        if (!Div_valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout actual=%0d expected=%0d", n, lat);
            if (sb.size() > 0) void'(sb.pop_back());
        end else begin
            chk("latency", n, lat);
            chk("busy_cycles", bn, lat);
            chk("busy_at_valid", {31'b0, Div_busy}, 32'h0);
        end
        @(negedge soc_clk);
        chk("valid_pulse_width", {31'b0, Div_valid}, 32'h0);
    endtask

    initial begin
        vec_t vecs[16];
        exp_t e;
        int   n;
        int   bn;

        vecs[0]  = '{5'd21, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 1'b0, 33};
        vecs[1]  = '{5'd20, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0, 1'b0, 1'b0, 33};
        vecs[2]  = '{5'd22, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 33};
        vecs[3]  = '{5'd23, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 1'b0, 33};
        vecs[4]  = '{5'd23, 32'd7,         32'd7,         32'd0,         1'b1, 1'b0, 1'b0, 33};
        vecs[5]  = '{5'd21, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1};
        vecs[6]  = '{5'd22, 32'd5,         32'd0,         32'd5,         1'b0, 1'b1, 1'b0, 1};
        vecs[7]  = '{5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 33};
        vecs[8]  = '{5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0, 1'b1, 33};
        vecs[9]  = '{5'd21, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33};
        vecs[10] = '{5'd20, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 33};
        vecs[11] = '{5'd22, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0, 1'b0, 1'b0, 33};
        vecs[12] = '{5'd20, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1};
        vecs[13] = '{5'd22, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0, 1};
        vecs[14] = '{5'd21, 32'd0,         32'd5,         32'd0,         1'b1, 1'b0, 1'b0, 33};
        vecs[15] = '{5'd23, 32'hFFFF_FFFF, 32'h10,        32'hF,         1'b0, 1'b0, 1'b0, 33};

        reset       = 1'b1;
        dat_ready   = 1'b0;
        ALU_dat1    = '0;
        ALU_dat2    = '0;
        decryptedOP = '0;
        repeat (3) @(posedge soc_clk);
        @(negedge soc_clk);
        chk("reset_out", Div_out, 32'h0);
        chk("reset_flags", {26'b0, Div_valid, Div_busy, Div_zero, Div_divbyzero, Div_overflow, 1'b0}, 32'h0);
        reset = 1'b0;
        @(negedge soc_clk);

        foreach (vecs[i]) begin
            e = '{vecs[i].out, vecs[i].zero, vecs[i].dbz, vecs[i].ovf};
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, e, vecs[i].lat);
        end

        for (int i = 0; i < 8; i++) begin
            logic [4:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 5'd20 + 5'(i % 4);
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            do_op(op, a, b, model(op, a, b), (b == 32'h0) ? 1 : 33);
        end

        // Non-divide opcodes must neither start nor disturb the last result.
        dat_ready = 1'b1;
        ALU_dat1  = 32'd50;
        ALU_dat2  = 32'd5;
        foreach (vecs[i]) begin
            if (i < 3) begin
                decryptedOP = (i == 0) ? 5'd0 : ((i == 1) ? 5'd19 : 5'd24);
                @(negedge soc_clk);
                chk("nondiv_busy", {31'b0, Div_busy}, 32'h0);
            end
        end
        dat_ready = 1'b0;
        @(negedge soc_clk);
        chk("nondiv_out_held", Div_out, last_out);

        // Reset ten cycles into RUN: no pulse, outputs cleared.
        dat_ready   = 1'b1;
        decryptedOP = 5'd21;
        ALU_dat1    = 32'd1000;
        ALU_dat2    = 32'd3;
        @(posedge soc_clk);
        @(negedge soc_clk);
        dat_ready = 1'b0;
        repeat (10) @(negedge soc_clk);
        chk("busy_before_reset", {31'b0, Div_busy}, 32'h1);
        reset = 1'b1;
        @(posedge soc_clk);
        @(negedge soc_clk);
        chk("midrun_reset_out", Div_out, 32'h0);
        chk("midrun_reset_flags", {27'b0, Div_valid, Div_busy, Div_zero, Div_divbyzero, Div_overflow}, 32'h0);
        reset = 1'b0;
        repeat (40) @(negedge soc_clk);
        chk("post_reset_idle", {31'b0, Div_busy}, 32'h0);
        do_op(5'd21, 32'd9, 32'd3, '{32'd3, 1'b0, 1'b0, 1'b0}, 33);

        // Reset and dat_ready on the same edge: nothing accepted.
        reset       = 1'b1;
        dat_ready   = 1'b1;
        decryptedOP = 5'd21;
        ALU_dat1    = 32'd20;
        ALU_dat2    = 32'd4;
        @(posedge soc_clk);
        @(negedge soc_clk);
        reset     = 1'b0;
        dat_ready = 1'b0;
        chk("reset_wins_busy", {31'b0, Div_busy}, 32'h0);
        @(negedge soc_clk);
        chk("reset_wins_no_start", {31'b0, Div_busy}, 32'h0);

        // Held dat_ready with changing operands; second op accepted on the valid cycle.
        dat_ready   = 1'b1;
        decryptedOP = 5'd21;
        ALU_dat1    = 32'd100;
        ALU_dat2    = 32'd7;
        sb.push_back('{32'd14, 1'b0, 1'b0, 1'b0});
        @(posedge soc_clk);
        @(negedge soc_clk);
        decryptedOP = 5'd23;
        ALU_dat1    = 32'd50;
        ALU_dat2    = 32'd9;
        sb.push_back('{32'd5, 1'b0, 1'b0, 1'b0});
        wait_valid(n, bn);
        chk("held_first_latency", n, 33);
        @(posedge soc_clk);
        @(negedge soc_clk);
        dat_ready = 1'b0;
        chk("b2b_valid_dropped", {31'b0, Div_valid}, 32'h0);
        chk("b2b_accepted_busy", {31'b0, Div_busy}, 32'h1);
        wait_valid(n, bn);
        chk("b2b_second_latency", n, 33);
        @(negedge soc_clk);
        repeat (3) @(negedge soc_clk);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_divrem.md
# alu_divrem

Iterative 32-bit integer divider/remainder unit inside the ALU, beside the single-cycle add/sub path. It takes the same operand/opcode bundle (ALU_dat1, ALU_dat2, decryptedOP, dat_ready) and handles the RV32M DIV/DIVU/REM/REMU opcodes. It produces one result bit per cycle (restoring shift-subtract) and reports completion with a one-cycle valid pulse plus busy and status flags.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- soc_clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high; clock soc_clk.
- dat_ready  in  1  operands and opcode valid this cycle.
- ALU_dat1  in  32  dividend.
- ALU_dat2  in  32  divisor.
- decryptedOP  in  5  opcode: OP_DIV=20, OP_DIVU=21, OP_REM=22, OP_REMU=23; all other codes are ignored.
- Div_out  out  32  quotient (DIV/DIVU) or remainder (REM/REMU); held until the next completion.
- Div_valid  out  1  one-cycle pulse when Div_out and the flags are new.
- Div_busy  out  1  high while an operation is in flight.
- Div_zero  out  1  Div_out == 0, registered with the result.
- Div_divbyzero  out  1  divisor was 0 for the completed operation.
- Div_overflow  out  1  signed op with dividend 0x80000000 and divisor 0xFFFFFFFF.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - Accept when dat_ready=1 and decryptedOP is in {20..23}.
  - Latch the op, the magnitudes of both operands (signed ops: two's-complement if negative; unsigned: raw), quotient sign = sign1 XOR sign2, and remainder sign = sign1.
  - Clear the partial remainder and set the counter to 0.
  - Divisor 0: go to DONE directly. Otherwise go to RUN.
- RUN, each cycle:
  - Shift {rem, quo} left by 1, bringing the dividend MSB into rem[0].
  - Compute a 33-bit trial rem − divisor. If it is non-negative, rem takes the difference and quo[0]=1.
  - Increment the counter. After the 32nd step (counter==31), go to DONE.
- DONE, one cycle:
  - Apply the signs (negate the quotient if its sign is set; negate the remainder if its sign is set).
  - Select quotient or remainder per op and register Div_out and the flags. Pulse Div_valid. Go to IDLE.
- Divide by zero: quotient 0xFFFFFFFF, remainder = original ALU_dat1, Div_divbyzero=1.
- Signed overflow: falls out of the magnitude path. Quotient 0x80000000, remainder 0, Div_overflow=1.
- dat_ready, ALU_dat1, ALU_dat2 and decryptedOP are sampled only in IDLE. Changes during RUN/DONE have no effect; there is no abort except reset.
- Non-divide opcodes never start an operation and leave the outputs unchanged.

## Timing
- Reset values: state IDLE; Div_out=0, Div_valid=0, Div_busy=0, Div_zero=0, Div_divbyzero=0, Div_overflow=0; internal registers 0.
- Accept edge is E0. RUN occupies E1..E32. The DONE edge E33 registers the result, so Div_valid=1 in the cycle after E33 and it drops after E34.
- Latency: 33 cycles from accept to valid. Divide by zero: 1 cycle (valid after E1).
- Div_busy = (state != IDLE). It is high in the cycles after E0..E32 and low in the Div_valid cycle.
- Back-to-back: a new accept is allowed at the edge where Div_valid is high (E34). Throughput is one op per 34 cycles, or per 2 cycles for divide by zero.
- Reset asserted mid-operation: at the next edge all outputs return to reset values, with no Div_valid pulse and no partial result exposed.
- Reset and dat_ready high on the same edge: reset wins and nothing is accepted.

## Structure
- Shared ALU package: opcode constants OP_DIV/OP_DIVU/OP_REM/OP_REMU and the state enum {IDLE, RUN, DONE}.
- Reuse the existing twoscomp block for operand magnitude and result sign fix-up.
- One natural sub-module, div_step: combinational single restoring iteration. Inputs rem[31:0], quo[31:0], divisor; outputs next rem and quo.
- The counter is 5 bits.

## Test plan
- DIVU 100/7, dat_ready for 1 cycle -> Div_busy high 33 cycles; Div_valid at E0+34 cycle with Div_out=14; flags 0.
- DIV 0xFFFFFF9C(−100)/7 -> 0xFFFFFFF2 (−14). REM same operands -> 0xFFFFFFFE (−2). REMU 100/7 -> 2. REMU 7/7 -> 0 with Div_zero=1.
- DIVU 5/0 -> 0xFFFFFFFF, Div_divbyzero=1, valid 1 cycle after accept. REM 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000, Div_overflow=1. REM same operands -> 0, Div_zero=1.
- Reset pulsed 10 cycles into RUN -> outputs all 0, busy 0, no valid pulse. A following DIVU 9/3 returns 3 after the normal latency.
- Change operands and hold dat_ready=1 through busy -> the first result is unaffected. A second op presented on the valid cycle is accepted and completes 34 cycles later.
